// File: rtl/jedro_1_mem_arbiter.sv
// Two-master (instr/data) to one-slave memory arbiter with round-robin grant,
// request lock under backpressure and an in-order ID FIFO for response steering.
module jedro_1_mem_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,

    input  logic [DATA_WIDTH-1:0] instr_req_addr_i,
    input  logic [DATA_WIDTH-1:0] instr_req_data_i,
    input  logic [3:0]            instr_req_strobe_i,
    input  logic                  instr_req_write_i,
    input  logic                  instr_req_valid_i,
    output logic                  instr_req_ready_o,
    output logic [DATA_WIDTH-1:0] instr_rsp_data_o,
    output logic                  instr_rsp_err_o,
    output logic                  instr_rsp_valid_o,
    input  logic                  instr_rsp_ready_i,

    input  logic [DATA_WIDTH-1:0] data_req_addr_i,
    input  logic [DATA_WIDTH-1:0] data_req_data_i,
    input  logic [3:0]            data_req_strobe_i,
    input  logic                  data_req_write_i,
    input  logic                  data_req_valid_i,
    output logic                  data_req_ready_o,
    output logic [DATA_WIDTH-1:0] data_rsp_data_o,
    output logic                  data_rsp_err_o,
    output logic                  data_rsp_valid_o,
    input  logic                  data_rsp_ready_i,

    output logic [DATA_WIDTH-1:0] mem_req_addr_o,
    output logic [DATA_WIDTH-1:0] mem_req_data_o,
    output logic [3:0]            mem_req_strobe_o,
    output logic                  mem_req_write_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
    input  logic                  mem_rsp_err_i,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o,

    output logic                  unexpected_rsp_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ID_INSTR = 1'b0,
        ID_DATA  = 1'b1
    } master_id_e;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    master_id_e       r_grant;
    master_id_e       w_grant_next;
    master_id_e       r_last_grant;
    master_id_e       w_grant;
    logic             w_has_grant;
    logic             w_gnt_valid;

    master_id_e       r_id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_unexpected;

    logic             w_full;
    logic             w_empty;
    master_id_e       w_head;
    logic             w_req_hs;
    logic             w_rsp_hs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_id_fifo[r_rd_ptr];

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_grant     = ID_INSTR;
        w_has_grant = 1'b0;
        if (r_state == ARB_LOCKED) begin
            w_grant     = r_grant;
            w_has_grant = 1'b1;
        end else if (instr_req_valid_i && data_req_valid_i) begin
            w_grant     = (r_last_grant == ID_INSTR) ? ID_DATA : ID_INSTR;
            w_has_grant = 1'b1;
        end else if (instr_req_valid_i) begin
            w_grant     = ID_INSTR;
            w_has_grant = 1'b1;
        end else if (data_req_valid_i) begin
            w_grant     = ID_DATA;
            w_has_grant = 1'b1;
        end
    end

    assign w_gnt_valid = w_has_grant &
                         ((w_grant == ID_DATA) ? data_req_valid_i : instr_req_valid_i);

    assign mem_req_addr_o   = (w_grant == ID_DATA) ? data_req_addr_i    : instr_req_addr_i;
    assign mem_req_data_o   = (w_grant == ID_DATA) ? data_req_data_i    : instr_req_data_i;
    assign mem_req_strobe_o = (w_grant == ID_DATA) ? data_req_strobe_i  : instr_req_strobe_i;
    assign mem_req_write_o  = (w_grant == ID_DATA) ? data_req_write_i   : instr_req_write_i;
    assign mem_req_valid_o  = w_gnt_valid & ~w_full;

    assign instr_req_ready_o = w_has_grant & (w_grant == ID_INSTR) & mem_req_ready_i & ~w_full;
    assign data_req_ready_o  = w_has_grant & (w_grant == ID_DATA)  & mem_req_ready_i & ~w_full;

    assign w_req_hs = mem_req_valid_o & mem_req_ready_i;

    // Lock holds the grant while an offer is stalled; a full FIFO keeps it locked.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        case (r_state)
            ARB_FREE: begin
                if (mem_req_valid_o && !mem_req_ready_i) begin
                    w_state_next = ARB_LOCKED;
                    w_grant_next = w_grant;
                end
            end
            ARB_LOCKED: begin
                if (w_req_hs) begin
                    w_state_next = ARB_FREE;
                end
            end
            default: w_state_next = ARB_FREE;
        endcase
    end

    assign instr_rsp_data_o  = mem_rsp_data_i;
    assign instr_rsp_err_o   = mem_rsp_err_i;
    assign data_rsp_data_o   = mem_rsp_data_i;
    assign data_rsp_err_o    = mem_rsp_err_i;
    assign instr_rsp_valid_o = mem_rsp_valid_i & ~w_empty & (w_head == ID_INSTR);
    assign data_rsp_valid_o  = mem_rsp_valid_i & ~w_empty & (w_head == ID_DATA);
    // With nothing outstanding the response is accepted and dropped.
    assign mem_rsp_ready_o   = w_empty ? 1'b1 :
                               ((w_head == ID_DATA) ? data_rsp_ready_i : instr_rsp_ready_i);

    assign w_rsp_hs = mem_rsp_valid_i & mem_rsp_ready_o & ~w_empty;

    assign unexpected_rsp_o = r_unexpected;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ARB_FREE;
            r_grant      <= ID_INSTR;
            r_last_grant <= ID_DATA;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_unexpected <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_unexpected <= mem_rsp_valid_i & w_empty;
            if (w_req_hs) begin
                r_last_grant <= w_grant;
                r_wr_ptr     <= ptr_inc(r_wr_ptr);
            end
            if (w_rsp_hs) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_req_hs, w_rsp_hs})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: ID storage has no reset; entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (w_req_hs) begin
            r_id_fifo[r_wr_ptr] <= w_grant;
        end
    end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Randomized bench for jedro_1_mem_arbiter: transaction-level reference model,
// per-master response scoreboards and a queue-based memory responder.
module tb_jedro_1_mem_arbiter;

    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [1:0]    m_valid;
    logic [DW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [3:0]    m_strb  [2];
    logic [1:0]    m_write;
    logic [1:0]    m_rsp_ready;

    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic          mem_rsp_err;
    logic [DW-1:0] mem_rsp_data;

    logic          instr_req_ready_o, data_req_ready_o;
    logic [DW-1:0] instr_rsp_data_o, data_rsp_data_o;
    logic          instr_rsp_err_o, data_rsp_err_o;
    logic          instr_rsp_valid_o, data_rsp_valid_o;
    logic [DW-1:0] mem_req_addr_o, mem_req_data_o;
    logic [3:0]    mem_req_strobe_o;
    logic          mem_req_write_o, mem_req_valid_o, mem_rsp_ready_o;
    logic          unexpected_rsp_o;

    jedro_1_mem_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .instr_req_addr_i   (m_addr[0]),
        .instr_req_data_i   (m_wdata[0]),
        .instr_req_strobe_i (m_strb[0]),
        .instr_req_write_i  (m_write[0]),
        .instr_req_valid_i  (m_valid[0]),
        .instr_req_ready_o  (instr_req_ready_o),
        .instr_rsp_data_o   (instr_rsp_data_o),
        .instr_rsp_err_o    (instr_rsp_err_o),
        .instr_rsp_valid_o  (instr_rsp_valid_o),
        .instr_rsp_ready_i  (m_rsp_ready[0]),
        .data_req_addr_i    (m_addr[1]),
        .data_req_data_i    (m_wdata[1]),
        .data_req_strobe_i  (m_strb[1]),
        .data_req_write_i   (m_write[1]),
        .data_req_valid_i   (m_valid[1]),
        .data_req_ready_o   (data_req_ready_o),
        .data_rsp_data_o    (data_rsp_data_o),
        .data_rsp_err_o     (data_rsp_err_o),
        .data_rsp_valid_o   (data_rsp_valid_o),
        .data_rsp_ready_i   (m_rsp_ready[1]),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_req_data_o     (mem_req_data_o),
        .mem_req_strobe_o   (mem_req_strobe_o),
        .mem_req_write_o    (mem_req_write_o),
        .mem_req_valid_o    (mem_req_valid_o),
        .mem_req_ready_i    (mem_req_ready),
        .mem_rsp_data_i     (mem_rsp_data),
        .mem_rsp_err_i      (mem_rsp_err),
        .mem_rsp_valid_i    (mem_rsp_valid),
        .mem_rsp_ready_o    (mem_rsp_ready_o),
        .unexpected_rsp_o   (unexpected_rsp_o)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } rsp_t;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The memory answers every address with a fixed function of it.
    function automatic logic [DW-1:0] rsp_word(input logic [DW-1:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    rsp_t          exp_q0[$];
    rsp_t          exp_q1[$];
    logic [DW-1:0] mem_q[$];

    // Reference state: outstanding owners in order, last winner, pending stalled offer.
    bit ref_outq[$];
    bit ref_locked, ref_lock_id, ref_last, ref_prev_unexp;
    bit mon_en;
    bit [1:0] acc;
    bit acc_rsp;

    bit t_full, t_empty, t_has, t_gnt, t_gvalid, t_exp_mv, t_head;
    bit t_exp_iv, t_exp_dv, t_pop, t_push;
    rsp_t t_r;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                ref_outq.delete();
                ref_locked     = 1'b0;
                ref_lock_id    = 1'b0;
                ref_last       = 1'b1;
                ref_prev_unexp = 1'b0;
                acc            = 2'b00;
                acc_rsp        = 1'b0;
            end else begin
                t_full  = (ref_outq.size() == MAXO);
                t_empty = (ref_outq.size() == 0);
                t_head  = t_empty ? 1'b0 : ref_outq[0];

                t_has = 1'b1;
                if (ref_locked)             t_gnt = ref_lock_id;
                else if (m_valid == 2'b11)  t_gnt = ~ref_last;
                else if (m_valid[0])        t_gnt = 1'b0;
                else if (m_valid[1])        t_gnt = 1'b1;
                else begin t_has = 1'b0;    t_gnt = 1'b0; end
                t_gvalid = t_has && m_valid[t_gnt];
                t_exp_mv = t_gvalid && !t_full;

                check("mem_req_valid", 64'(mem_req_valid_o), 64'(t_exp_mv));
                check("instr_req_ready", 64'(instr_req_ready_o),
                      64'(t_has && !t_gnt && mem_req_ready && !t_full));
                check("data_req_ready", 64'(data_req_ready_o),
                      64'(t_has && t_gnt && mem_req_ready && !t_full));
                if (t_exp_mv) begin
                    check("mem_req_addr", 64'(mem_req_addr_o), 64'(m_addr[t_gnt]));
                    check("mem_req_data", 64'(mem_req_data_o), 64'(m_wdata[t_gnt]));
                    check("mem_req_strb_wr", 64'({mem_req_strobe_o, mem_req_write_o}),
                          64'({m_strb[t_gnt], m_write[t_gnt]}));
                end

                t_exp_iv = mem_rsp_valid && !t_empty && !t_head;
                t_exp_dv = mem_rsp_valid && !t_empty && t_head;
                check("instr_rsp_valid", 64'(instr_rsp_valid_o), 64'(t_exp_iv));
                check("data_rsp_valid", 64'(data_rsp_valid_o), 64'(t_exp_dv));
                if (mem_rsp_valid)
                    check("mem_rsp_ready", 64'(mem_rsp_ready_o),
                          64'(t_empty ? 1'b1 : m_rsp_ready[t_head]));
                check("unexpected_rsp", 64'(unexpected_rsp_o), 64'(ref_prev_unexp));

                acc[0] = m_valid[0] && instr_req_ready_o;
                acc[1] = m_valid[1] && data_req_ready_o;
                if (acc[0]) begin
                    t_r.d = rsp_word(m_addr[0]); t_r.e = m_addr[0][4];
                    exp_q0.push_back(t_r);
                end
                if (acc[1]) begin
                    t_r.d = rsp_word(m_addr[1]); t_r.e = m_addr[1][4];
                    exp_q1.push_back(t_r);
                end
                if (instr_rsp_valid_o && m_rsp_ready[0]) begin
                    if (exp_q0.size() == 0) check("instr_rsp_unrequested", 64'd1, 64'd0);
                    else begin
                        t_r = exp_q0.pop_front();
                        check("instr_rsp_data", 64'(instr_rsp_data_o), 64'(t_r.d));
                        check("instr_rsp_err", 64'(instr_rsp_err_o), 64'(t_r.e));
                    end
                end
                if (data_rsp_valid_o && m_rsp_ready[1]) begin
                    if (exp_q1.size() == 0) check("data_rsp_unrequested", 64'd1, 64'd0);
                    else begin
                        t_r = exp_q1.pop_front();
                        check("data_rsp_data", 64'(data_rsp_data_o), 64'(t_r.d));
                        check("data_rsp_err", 64'(data_rsp_err_o), 64'(t_r.e));
                    end
                end

                if (mem_req_valid_o && mem_req_ready) mem_q.push_back(mem_req_addr_o);
                acc_rsp = mem_rsp_valid && mem_rsp_ready_o;
                if (acc_rsp && mem_q.size() > 0) void'(mem_q.pop_front());

                t_pop  = !t_empty && mem_rsp_valid && m_rsp_ready[t_head];
                t_push = t_exp_mv && mem_req_ready;
                if (t_pop) void'(ref_outq.pop_front());
                if (t_push) begin
                    ref_outq.push_back(t_gnt);
                    ref_last   = t_gnt;
                    ref_locked = 1'b0;
                end else if (t_exp_mv) begin
                    ref_locked  = 1'b1;
                    ref_lock_id = t_gnt;
                end
                ref_prev_unexp = mem_rsp_valid && t_empty;
            end
        end
    end

    // Masters hold a request until accepted; the memory holds a response until taken.
    task automatic drive_cycle(input int p_req, input int p_mr, input int p_rsp, input int p_rr);
        for (int m = 0; m < 2; m++) begin
            if (!m_valid[m] || acc[m]) begin
                m_valid[m] = ($urandom_range(99) < p_req);
                m_addr[m]  = $urandom & 32'hFFFF_FFFC;
                m_wdata[m] = $urandom;
                m_strb[m]  = 4'($urandom);
                m_write[m] = 1'($urandom);
            end
        end
        mem_req_ready = ($urandom_range(99) < p_mr);
        if (!mem_rsp_valid || acc_rsp) begin
            if (mem_q.size() > 0 && $urandom_range(99) < p_rsp) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rsp_word(mem_q[0]);
                mem_rsp_err   = mem_q[0][4];
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = $urandom;
                mem_rsp_err   = 1'b0;
            end
        end
        m_rsp_ready[0] = ($urandom_range(99) < p_rr);
        m_rsp_ready[1] = ($urandom_range(99) < p_rr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    bit done;

    initial begin
        mon_en        = 1'b0;
        rstn          = 1'b0;
        m_valid       = 2'b00;
        m_write       = 2'b00;
        m_rsp_ready   = 2'b00;
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0; m_wdata[m] = '0; m_strb[m] = '0;
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        mem_rsp_data  = '0;

        #12;
        check("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_instr_req_ready", 64'(instr_req_ready_o), 64'd0);
        check("rst_data_req_ready", 64'(data_req_ready_o), 64'd0);
        check("rst_instr_rsp_valid", 64'(instr_rsp_valid_o), 64'd0);
        check("rst_data_rsp_valid", 64'(data_rsp_valid_o), 64'd0);
        check("rst_unexpected", 64'(unexpected_rsp_o), 64'd0);
        @(negedge clk) rstn = 1'b1;

        // Single instruction read at 0x100 answered the next cycle.
        @(posedge clk); #1;
        mon_en        = 1'b1;
        m_valid[0]    = 1'b1;
        m_addr[0]     = 32'h100;
        mem_req_ready = 1'b1;
        m_rsp_ready   = 2'b11;
        #1 check("single_addr", 64'(mem_req_addr_o), 64'h100);
        @(posedge clk); #1;
        m_valid[0]    = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_word(32'h100);
        mem_rsp_err   = 1'b0;
        #1 check("single_rsp_valid", 64'(instr_rsp_valid_o), 64'd1);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;

        // Saturated traffic for tie alternation, then mixed and lock-heavy random traffic.
        repeat (40)   begin @(posedge clk); #1; drive_cycle(100, 100, 100, 100); end
        repeat (3000) begin @(posedge clk); #1; drive_cycle(60, 60, 40, 70); end
        repeat (500)  begin @(posedge clk); #1; drive_cycle(80, 25, 50, 80); end

        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            done = (m_valid == 2'b00) && !mem_rsp_valid && (mem_q.size() == 0) &&
                   (exp_q0.size() == 0) && (exp_q1.size() == 0);
            if (done) break;
            drive_cycle(0, 100, 100, 100);
        end
        check("drain_done", 64'(done), 64'd1);

        // Response with nothing outstanding.
        m_valid       = 2'b00;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        #1 check("unexp_no_deliver", 64'({instr_rsp_valid_o, data_rsp_valid_o}), 64'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        check("unexp_pulse", 64'(unexpected_rsp_o), 64'd1);
        @(posedge clk); #1;
        check("unexp_pulse_end", 64'(unexpected_rsp_o), 64'd0);

        // Asynchronous reset with one request outstanding.
        mon_en        = 1'b0;
        m_valid[0]    = 1'b1;
        m_addr[0]     = 32'h200;
        mem_req_ready = 1'b1;
        m_rsp_ready   = 2'b00;
        #1 check("rst_setup_accept", 64'(instr_req_ready_o), 64'd1);
        @(posedge clk); #1;
        m_valid[0]    = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rsp_word(32'h200);
        #1 check("rst_setup_pending", 64'({instr_rsp_valid_o, mem_rsp_ready_o}), 64'b10);
        rstn = 1'b0;
        #1;
        check("arst_instr_rsp_valid", 64'(instr_rsp_valid_o), 64'd0);
        check("arst_data_rsp_valid", 64'(data_rsp_valid_o), 64'd0);
        check("arst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("arst_mem_rsp_ready", 64'(mem_rsp_ready_o), 64'd1);
        check("arst_unexpected", 64'(unexpected_rsp_o), 64'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        check("post_rst_unexp", 64'(unexpected_rsp_o), 64'd1);
        check("post_rst_no_deliver", 64'({instr_rsp_valid_o, data_rsp_valid_o}), 64'd0);
        @(posedge clk); #1;
        check("post_rst_unexp_end", 64'(unexpected_rsp_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
